// File: rtl/tree_pkg.sv
// Shared types and constants for the message-tree path matcher.
// Holds the sizing constants, identifier/path/entry types, the op encoding,
// the result payload and a small default table (Person, PhoneNumber).
package tree_pkg;

    localparam int unsigned MAX_DEPTH   = 4;
    localparam int unsigned NUM_ENTRIES = 8;
    localparam int unsigned ID_W        = 5;
    localparam int unsigned DATA_W      = 4;
    localparam int unsigned IDX_W       = $clog2(NUM_ENTRIES);
    localparam int unsigned DEPTH_W     = $clog2(MAX_DEPTH + 1);
    localparam int unsigned LVL_W       = (MAX_DEPTH > 1) ? $clog2(MAX_DEPTH) : 1;
    localparam int unsigned PATH_W      = MAX_DEPTH * ID_W;

    typedef logic [ID_W-1:0]          identifier_t;
    typedef identifier_t [MAX_DEPTH-1:0] path_t;   // level 0 (root) in the low bits
    typedef logic [DEPTH_W-1:0]       depth_t;
    typedef logic [IDX_W-1:0]         idx_t;
    typedef logic [DATA_W-1:0]        data_t;

    typedef enum logic [1:0] {
        OP_PUSH  = 2'd0,
        OP_POP   = 2'd1,
        OP_CLEAR = 2'd2,
        OP_RSVD  = 2'd3
    } tree_op_t;

    typedef struct packed {
        logic   valid;
        depth_t depth;
        path_t  path;
        data_t  data;
    } entry_t;

    // Lookup result as presented to the field handlers.
    typedef struct packed {
        logic   hit;
        idx_t   idx;
        data_t  data;
        depth_t depth;
        logic   err;
    } result_t;

    // Default table contents: Person = {1}, Person.PhoneNumber = {1,4}.
    localparam identifier_t ID_PERSON         = ID_W'(1);
    localparam identifier_t ID_PHONE_NUMBER   = ID_W'(4);
    localparam data_t       DATA_PERSON       = DATA_W'(0);
    localparam data_t       DATA_PHONE_NUMBER = DATA_W'(1);

    // A depth of zero marks the entry invalid.
    function automatic entry_t make_entry(input path_t p, input depth_t d, input data_t x);
        entry_t e;
        e.valid = (d != '0);
        e.depth = d;
        e.path  = p;
        e.data  = x;
        return e;
    endfunction

endpackage

// File: rtl/tree_path_entry_cmp.sv
// Combinational compare of one dependency-table entry against the current stack.
// Ports: entry (table entry), stack (current path), depth (current stack depth),
//        hit_c (entry matches the full root-to-node path).
module tree_path_entry_cmp
    import tree_pkg::*;
(
    input  entry_t                entry,
    input  path_t                 stack,
    input  logic [DEPTH_W-1:0]    depth,
    output logic                  hit_c
);

    logic levels_ok;

    // Only levels below the current depth take part; deeper stack slots are stale.
    always_comb begin
        levels_ok = 1'b1;
        for (int unsigned i = 0; i < MAX_DEPTH; i++) begin
            if ((DEPTH_W'(i) < depth) && (entry.path[i] != stack[i])) begin
                levels_ok = 1'b0;
            end
        end
        hit_c = entry.valid && (entry.depth == depth) && (depth != '0) && levels_ok;
    end

endmodule

// File: rtl/tree_path_matcher.sv
// Tracks the position in a message tree as a stack of field identifiers and,
// after every PUSH/POP, looks the root-to-node path up in a runtime-loaded table.
// Ports:
//   clk, rst_n                 clock, synchronous active-low reset
//   in_valid/in_ready          op handshake; in_op = PUSH/POP/CLEAR, in_id for PUSH
//   cfg_we/idx/path/depth/data table write port (depth 0 invalidates)
//   out_valid/out_ready        result handshake; out_hit/idx/data/depth/err payload
//   err_overflow/err_underflow sticky error flags, cleared by CLEAR
// Pipeline: accept (stack update) -> S1 registered per-entry compare -> S2 encode/select.
module tree_path_matcher
    import tree_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [1:0]          in_op,
    input  logic [ID_W-1:0]     in_id,
    input  logic                cfg_we,
    input  logic [IDX_W-1:0]    cfg_idx,
    input  logic [PATH_W-1:0]   cfg_path,
    input  logic [DEPTH_W-1:0]  cfg_depth,
    input  logic [DATA_W-1:0]   cfg_data,
    output logic                out_valid,
    input  logic                out_ready,
    output logic                out_hit,
    output logic [IDX_W-1:0]    out_idx,
    output logic [DATA_W-1:0]   out_data,
    output logic [DEPTH_W-1:0]  out_depth,
    output logic                out_err,
    output logic                err_overflow,
    output logic                err_underflow
);

    entry_t                 table_q [NUM_ENTRIES];
    path_t                  stack_q, stack_d;
    depth_t                 depth_q, depth_d;

    logic                   s0_valid_q, s0_err_q;
    logic                   s0_valid_d, s0_err_d;
    logic                   s1_valid_q, s1_err_q;
    depth_t                 s1_depth_q;
    logic [NUM_ENTRIES-1:0] s1_hits_q;
    logic [NUM_ENTRIES-1:0] hits_c;

    logic                   out_valid_q;
    result_t                res_q;

    logic                   s2_ready, accept;
    logic                   set_ovf, set_unf, clr_err;
    logic                   enc_hit;
    idx_t                   enc_idx;

    // S2 can load when empty or draining; S0/S1 advance together with in_ready.
    assign s2_ready = !out_valid_q || out_ready;
    assign in_ready = !s1_valid_q || s2_ready;
    assign accept   = in_valid && in_ready;

    // Op decode and next stack state.
    always_comb begin
        stack_d    = stack_q;
        depth_d    = depth_q;
        s0_valid_d = 1'b0;
        s0_err_d   = 1'b0;
        set_ovf    = 1'b0;
        set_unf    = 1'b0;
        clr_err    = 1'b0;
        if (accept) begin
            case (tree_op_t'(in_op))
                OP_PUSH: begin
                    s0_valid_d = 1'b1;
                    if (depth_q == DEPTH_W'(MAX_DEPTH)) begin
                        s0_err_d = 1'b1;
                        set_ovf  = 1'b1;
                    end else begin
                        stack_d[depth_q[LVL_W-1:0]] = in_id;
                        depth_d = depth_q + DEPTH_W'(1);
                    end
                end
                OP_POP: begin
                    s0_valid_d = 1'b1;
                    if (depth_q == '0) begin
                        s0_err_d = 1'b1;
                        set_unf  = 1'b1;
                    end else begin
                        depth_d = depth_q - DEPTH_W'(1);
                    end
                end
                default: begin
                    // CLEAR and the reserved code: reset position, no result.
                    depth_d = '0;
                    clr_err = 1'b1;
                end
            endcase
        end
    end

    // One comparator per table entry against the post-op stack.
    for (genvar g = 0; g < NUM_ENTRIES; g++) begin : g_cmp
        tree_path_entry_cmp u_cmp (
            .entry (table_q[g]),
            .stack (stack_q),
            .depth (depth_q),
            .hit_c (hits_c[g])
        );
    end

    // Lowest matching index wins.
    always_comb begin
        enc_hit = 1'b0;
        enc_idx = '0;
        for (int i = int'(NUM_ENTRIES) - 1; i >= 0; i--) begin
            if (s1_hits_q[i]) begin
                enc_hit = 1'b1;
                enc_idx = IDX_W'(i);
            end
        end
    end

    // Dependency table.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(NUM_ENTRIES); i++) begin
                table_q[i] <= '0;
            end
        end else if (cfg_we) begin
            table_q[cfg_idx] <= make_entry(path_t'(cfg_path), cfg_depth, cfg_data);
        end
    end

    // Stack and sticky errors.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stack_q       <= '0;
            depth_q       <= '0;
            err_overflow  <= 1'b0;
            err_underflow <= 1'b0;
        end else begin
            stack_q <= stack_d;
            depth_q <= depth_d;
            if (clr_err) begin
                err_overflow  <= 1'b0;
                err_underflow <= 1'b0;
            end else begin
                if (set_ovf) err_overflow  <= 1'b1;
                if (set_unf) err_underflow <= 1'b1;
            end
        end
    end

    // S0 (pending lookup) and S1 (registered compare vector).
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s0_valid_q <= 1'b0;
            s0_err_q   <= 1'b0;
            s1_valid_q <= 1'b0;
            s1_err_q   <= 1'b0;
            s1_depth_q <= '0;
            s1_hits_q  <= '0;
        end else if (in_ready) begin
            s0_valid_q <= s0_valid_d;
            s0_err_q   <= s0_err_d;
            s1_valid_q <= s0_valid_q;
            s1_err_q   <= s0_err_q;
            s1_depth_q <= depth_q;
            // An erroring op must never report a hit, even if the unchanged stack matches.
            s1_hits_q  <= s0_err_q ? '0 : hits_c;
        end
    end

    // S2 output register, held under backpressure.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            res_q       <= '0;
        end else if (s2_ready) begin
            out_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                res_q.hit   <= enc_hit;
                res_q.idx   <= enc_idx;
                res_q.data  <= enc_hit ? table_q[enc_idx].data : '0;
                res_q.depth <= s1_depth_q;
                res_q.err   <= s1_err_q;
            end
        end
    end

    assign out_valid = out_valid_q;
    assign out_hit   = res_q.hit;
    assign out_idx   = res_q.idx;
    assign out_data  = res_q.data;
    assign out_depth = res_q.depth;
    assign out_err   = res_q.err;

endmodule

// File: tb/tb_tree_path_matcher.sv
// Scoreboard bench for tree_path_matcher: a behavioural stack/table model
// queues the expected result of every accepted PUSH/POP; the monitor pops and
// compares each result the DUT hands over.
module tb_tree_path_matcher;
    import tree_pkg::*;

    logic                clk;
    logic                rst_n;
    logic                in_valid;
    logic                in_ready;
    logic [1:0]          in_op;
    logic [ID_W-1:0]     in_id;
    logic                cfg_we;
    logic [IDX_W-1:0]    cfg_idx;
    logic [PATH_W-1:0]   cfg_path;
    logic [DEPTH_W-1:0]  cfg_depth;
    logic [DATA_W-1:0]   cfg_data;
    logic                out_valid;
    logic                out_ready;
    logic                out_hit;
    logic [IDX_W-1:0]    out_idx;
    logic [DATA_W-1:0]   out_data;
    logic [DEPTH_W-1:0]  out_depth;
    logic                out_err;
    logic                err_overflow;
    logic                err_underflow;

    tree_path_matcher dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_op         (in_op),
        .in_id         (in_id),
        .cfg_we        (cfg_we),
        .cfg_idx       (cfg_idx),
        .cfg_path      (cfg_path),
        .cfg_depth     (cfg_depth),
        .cfg_data      (cfg_data),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_hit       (out_hit),
        .out_idx       (out_idx),
        .out_data      (out_data),
        .out_depth     (out_depth),
        .out_err       (out_err),
        .err_overflow  (err_overflow),
        .err_underflow (err_underflow)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int          checks = 0;
    int          errors = 0;
    result_t     exp_q[$];
    result_t     mon_exp;
    logic        saw_stall;

    // Behavioural model state.
    logic        m_valid [NUM_ENTRIES];
    int          m_len   [NUM_ENTRIES];
    identifier_t m_path  [NUM_ENTRIES][MAX_DEPTH];
    data_t       m_data  [NUM_ENTRIES];
    identifier_t m_stack [MAX_DEPTH];
    int          m_dep;
    logic        m_ovf, m_unf;

    tree_op_t    rop;
    identifier_t rid;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < int'(NUM_ENTRIES); i++) begin
            m_valid[i] = 1'b0;
            m_len[i]   = 0;
            m_data[i]  = '0;
            for (int l = 0; l < int'(MAX_DEPTH); l++) m_path[i][l] = '0;
        end
        for (int l = 0; l < int'(MAX_DEPTH); l++) m_stack[l] = '0;
        m_dep = 0;
        m_ovf = 1'b0;
        m_unf = 1'b0;
    endtask

    function automatic result_t model_result(input logic err);
        result_t r;
        logic    m;
        r       = '0;
        r.depth = DEPTH_W'(m_dep);
        r.err   = err;
        if (!err && m_dep != 0) begin
            for (int i = int'(NUM_ENTRIES) - 1; i >= 0; i--) begin
                m = m_valid[i] && (m_len[i] == m_dep);
                for (int l = 0; l < m_dep; l++) begin
                    if (m_path[i][l] != m_stack[l]) m = 1'b0;
                end
                if (m) begin
                    r.hit  = 1'b1;
                    r.idx  = IDX_W'(i);
                    r.data = m_data[i];
                end
            end
        end
        return r;
    endfunction

    task automatic model_apply(input tree_op_t op, input identifier_t id);
        case (op)
            OP_PUSH: begin
                if (m_dep == int'(MAX_DEPTH)) begin
                    m_ovf = 1'b1;
                    exp_q.push_back(model_result(1'b1));
                end else begin
                    m_stack[m_dep] = id;
                    m_dep++;
                    exp_q.push_back(model_result(1'b0));
                end
            end
            OP_POP: begin
                if (m_dep == 0) begin
                    m_unf = 1'b1;
                    exp_q.push_back(model_result(1'b1));
                end else begin
                    m_dep--;
                    exp_q.push_back(model_result(1'b0));
                end
            end
            default: begin
                m_dep = 0;
                m_ovf = 1'b0;
                m_unf = 1'b0;
            end
        endcase
    endtask

    // Called at a falling edge; the write lands on the next rising edge.
    task automatic cfg_write(input idx_t idx, input depth_t len, input identifier_t i0,
                             input identifier_t i1, input identifier_t i2,
                             input identifier_t i3, input data_t d);
        cfg_we    = 1'b1;
        cfg_idx   = idx;
        cfg_path  = {i3, i2, i1, i0};
        cfg_depth = len;
        cfg_data  = d;
        m_valid[idx]   = (len != '0);
        m_len[idx]     = int'(len);
        m_path[idx][0] = i0;
        m_path[idx][1] = i1;
        m_path[idx][2] = i2;
        m_path[idx][3] = i3;
        m_data[idx]    = d;
        @(negedge clk);
        cfg_we = 1'b0;
    endtask

    // Called at a falling edge; returns at the falling edge after acceptance.
    task automatic send_op(input tree_op_t op, input identifier_t id);
        int guard;
        guard    = 0;
        in_valid = 1'b1;
        in_op    = 2'(op);
        in_id    = id;
        #1;
        while (!in_ready && guard < 200) begin
            @(negedge clk);
            #1;
            guard++;
        end
        if (!in_ready) begin
            in_valid = 1'b0;
            check("in_ready_timeout", 32'(in_ready), 32'(1));
        end else begin
            model_apply(op, id);
            @(negedge clk);
            in_valid = 1'b0;
        end
    endtask

    task automatic wait_drain();
        int guard;
        guard = 0;
        while (exp_q.size() != 0 && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        check("drain_pending", 32'(exp_q.size()), 32'(0));
        repeat (2) @(negedge clk);
    endtask

    task automatic check_sticky();
        check("err_overflow", 32'(err_overflow), 32'(m_ovf));
        check("err_underflow", 32'(err_underflow), 32'(m_unf));
    endtask

    // Monitor: a transfer happens at the rising edge after a sample showing valid&ready.
    always begin
        @(negedge clk);
        #2;
        if (rst_n && in_valid && !in_ready) saw_stall = 1'b1;
        if (rst_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_result", 32'(out_valid), 32'(0));
            end else begin
                mon_exp = exp_q.pop_front();
                check("res_hit",   32'(out_hit),   32'(mon_exp.hit));
                check("res_idx",   32'(out_idx),   32'(mon_exp.idx));
                check("res_data",  32'(out_data),  32'(mon_exp.data));
                check("res_depth", 32'(out_depth), 32'(mon_exp.depth));
                check("res_err",   32'(out_err),   32'(mon_exp.err));
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_op     = '0;
        in_id     = '0;
        cfg_we    = 1'b0;
        cfg_idx   = '0;
        cfg_path  = '0;
        cfg_depth = '0;
        cfg_data  = '0;
        out_ready = 1'b1;
        saw_stall = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rst_out_valid", 32'(out_valid), 32'(0));
        check("rst_in_ready",  32'(in_ready),  32'(1));
        check("rst_out_hit",   32'(out_hit),   32'(0));
        check("rst_out_idx",   32'(out_idx),   32'(0));
        check("rst_out_data",  32'(out_data),  32'(0));
        check("rst_out_depth", 32'(out_depth), 32'(0));
        check("rst_out_err",   32'(out_err),   32'(0));
        check_sticky();
        @(negedge clk);

        // Person and Person.PhoneNumber lookups.
        cfg_write(IDX_W'(0), DEPTH_W'(1), ID_PERSON, '0, '0, '0, DATA_PERSON);
        cfg_write(IDX_W'(1), DEPTH_W'(2), ID_PERSON, ID_PHONE_NUMBER, '0, '0, DATA_PHONE_NUMBER);
        send_op(OP_PUSH, ID_PERSON);
        send_op(OP_PUSH, ID_PHONE_NUMBER);
        wait_drain();

        // Pop back to the root, then underflow.
        send_op(OP_POP, '0);
        send_op(OP_POP, '0);
        send_op(OP_POP, '0);
        wait_drain();
        check_sticky();

        // Overflow on the fifth push, then CLEAR wipes the stickies.
        send_op(OP_PUSH, ID_W'(1));
        send_op(OP_PUSH, ID_W'(4));
        send_op(OP_PUSH, ID_W'(2));
        send_op(OP_PUSH, ID_W'(3));
        send_op(OP_PUSH, ID_W'(6));
        wait_drain();
        check_sticky();
        send_op(OP_CLEAR, '0);
        repeat (2) @(negedge clk);
        check_sticky();

        // Duplicate paths: lowest index wins, invalidation falls through.
        cfg_write(IDX_W'(0), DEPTH_W'(0), '0, '0, '0, '0, '0);
        cfg_write(IDX_W'(2), DEPTH_W'(1), ID_W'(1), '0, '0, '0, DATA_W'(3));
        cfg_write(IDX_W'(5), DEPTH_W'(1), ID_W'(1), '0, '0, '0, DATA_W'(7));
        send_op(OP_PUSH, ID_W'(1));
        wait_drain();
        cfg_write(IDX_W'(2), DEPTH_W'(0), '0, '0, '0, '0, '0);
        send_op(OP_POP, '0);
        send_op(OP_PUSH, ID_W'(1));
        wait_drain();

        // Back-to-back ops against a stalled consumer.
        out_ready = 1'b0;
        saw_stall = 1'b0;
        fork
            begin
                repeat (4) @(negedge clk);
                out_ready = 1'b1;
            end
            begin
                send_op(OP_PUSH, ID_W'(4));
                send_op(OP_PUSH, ID_W'(2));
                send_op(OP_PUSH, ID_W'(3));
                send_op(OP_POP, '0);
                send_op(OP_POP, '0);
                send_op(OP_POP, '0);
            end
        join
        check("stall_seen", 32'(saw_stall), 32'(1));
        wait_drain();

        // Random push/pop stream with a jittery consumer.
        fork
            begin
                for (int k = 0; k < 60; k++) begin
                    @(negedge clk);
                    out_ready = ($urandom_range(0, 3) != 0);
                end
                out_ready = 1'b1;
            end
            begin
                for (int k = 0; k < 24; k++) begin
                    rop = ($urandom_range(0, 2) != 0) ? OP_PUSH : OP_POP;
                    rid = ID_W'($urandom_range(1, 4));
                    send_op(rop, rid);
                end
            end
        join
        wait_drain();
        check_sticky();
        send_op(OP_CLEAR, '0);
        repeat (2) @(negedge clk);
        check_sticky();

        // Reset with two results in flight.
        out_ready = 1'b0;
        send_op(OP_PUSH, ID_W'(1));
        send_op(OP_PUSH, ID_W'(4));
        rst_n = 1'b0;
        exp_q.delete();
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("postrst_out_valid", 32'(out_valid), 32'(0));
        check("postrst_out_depth", 32'(out_depth), 32'(0));
        check("postrst_in_ready",  32'(in_ready),  32'(1));
        check_sticky();
        @(negedge clk);
        out_ready = 1'b1;
        send_op(OP_PUSH, ID_W'(1));
        wait_drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
